// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the IMEM program loader.
// Optional checksum trailer support is selected with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_HI,
    ST_RX_LO,
    ST_WRITE,
    ST_CHECK,
    ST_DONE
  } loader_state_e;

  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 2;
  localparam int CSUM_W         = 8;

  // A new load may only begin from a quiescent state.
  function automatic logic start_allowed(input loader_state_e s);
    return (s == ST_IDLE) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/imem_program_loader_if.sv
// Host byte link plus IMEM write port of the program loader.
// master = loader side, slave = host / memory side.
interface imem_program_loader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [ADDR_W-1:0] write_select;
  logic [DATA_W-1:0] imem_input;
  logic              write_enable;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    input  start, byte_in, byte_valid,
    output byte_ready, write_select, imem_input, write_enable,
           cpu_hold, busy, done, error
  );

  modport slave (
    output start, byte_in, byte_valid,
    input  byte_ready, write_select, imem_input, write_enable,
           cpu_hold, busy, done, error
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles two bytes (high first) into one IMEM word.
// With IMEM_LOADER_CHECKSUM_EN it also keeps a mod-256 sum of every data byte.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clear,
  input  logic                               load_hi,
  input  logic                               load_lo,
  input  logic [BYTE_W-1:0]                  byte_in,
  output logic [BYTES_PER_WORD*BYTE_W-1:0]   word
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [CSUM_W-1:0]                  csum
`endif
);

  logic [BYTE_W-1:0] hi_q;

  // word only updates on the low byte, so it holds the last written value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      word <= '0;
    end else begin
      if (clear) begin
        hi_q <= '0;
      end else if (load_hi) begin
        hi_q <= byte_in;
      end
      if (load_lo) begin
        word <= {hi_q, byte_in};
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= '0;
    end else if (clear) begin
      csum <= '0;
    end else if (load_hi || load_lo) begin
      csum <= csum + byte_in;
    end
  end
`endif

endmodule

// File: rtl/imem_program_loader.sv
// Loads a DEPTH-word program image from a byte stream into IMEM while holding the CPU.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing checksum byte after the image.
module imem_program_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  imem_program_loader_if.master lif,
  output loader_state_e         dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  loader_state_e               state;
  logic [ADDR_W-1:0]           addr;
  logic                        ready_q;
  logic [ADDR_W-1:0]           wsel_q;
  logic                        we_q;
  logic                        hold_q;
  logic                        busy_q;
  logic                        done_q;
  logic                        xfer;
  logic                        start_ok;
  logic                        load_hi;
  logic                        load_lo;
  logic [BYTES_PER_WORD*BYTE_W-1:0] word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [CSUM_W-1:0]           csum;
  logic                        error_q;
`endif

  // Handshake: a byte moves on a rising edge where byte_valid && byte_ready;
  // byte_ready is registered and only high in RX_HI, RX_LO and CHECK, and a
  // byte offered while byte_ready is low stays pending at the source.
  assign xfer     = lif.byte_valid && ready_q;
  assign start_ok = lif.start && start_allowed(state);
  assign load_hi  = (state == ST_RX_HI) && xfer;
  assign load_lo  = (state == ST_RX_LO) && xfer;

  imem_loader_byte_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_ok),
    .load_hi (load_hi),
    .load_lo (load_lo),
    .byte_in (lif.byte_in),
    .word    (word)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .csum    (csum)
`endif
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      addr    <= '0;
      ready_q <= 1'b0;
      wsel_q  <= '0;
      we_q    <= 1'b0;
      hold_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      error_q <= 1'b0;
`endif
    end else begin
      we_q <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            state   <= ST_RX_HI;
            addr    <= '0;
            done_q  <= 1'b0;
            hold_q  <= 1'b1;
            busy_q  <= 1'b1;
            ready_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            error_q <= 1'b0;
`endif
          end
        end
        ST_RX_HI: begin
          if (xfer) state <= ST_RX_LO;
        end
        ST_RX_LO: begin
          // Strobe is raised on entry so it is high for exactly the WRITE cycle.
          if (xfer) begin
            state   <= ST_WRITE;
            ready_q <= 1'b0;
            we_q    <= 1'b1;
            wsel_q  <= addr;
          end
        end
        ST_WRITE: begin
          if (addr == LAST_ADDR) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state   <= ST_CHECK;
            ready_q <= 1'b1;
`else
            state   <= ST_DONE;
            done_q  <= 1'b1;
            hold_q  <= 1'b0;
            busy_q  <= 1'b0;
`endif
          end else begin
            addr    <= addr + 1'b1;
            state   <= ST_RX_HI;
            ready_q <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (xfer) begin
            state   <= ST_DONE;
            ready_q <= 1'b0;
            error_q <= (lif.byte_in != csum);
            done_q  <= 1'b1;
            hold_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign lif.byte_ready   = ready_q;
  assign lif.write_select = wsel_q;
  assign lif.imem_input   = word;
  assign lif.write_enable = we_q;
  assign lif.cpu_hold     = hold_q;
  assign lif.busy         = busy_q;
  assign lif.done         = done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign lif.error        = error_q;
`else
  assign lif.error        = 1'b0;
`endif
  assign dbg_state        = state;

endmodule

// File: tb/tb_imem_program_loader.sv
// Bench for imem_program_loader: randomized byte streams, a reference image model
// and a write scoreboard; builds with or without IMEM_LOADER_CHECKSUM_EN.
module tb_imem_program_loader;
  import imem_loader_pkg::*;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int DATA_W = 16;
  localparam int EXP_W  = ADDR_W + DATA_W;
  localparam int NBYTES = 2 * DEPTH;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  loader_state_e dbg_state;

  imem_program_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) lif ();

  imem_program_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .lif       (lif),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int                n_checks = 0;
  int                n_fail   = 0;
  logic [EXP_W-1:0]  exp_q[$];
  logic [7:0]        img[0:NBYTES];
  logic [DATA_W-1:0] mem[0:DEPTH-1];
  int                load_id = 0;
  bit                tight   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic [EXP_W-1:0] mon_got, mon_exp;
  int mon_load_id = -1;
  int prev_we_cyc = 0;

  always @(negedge clk) begin
    if (!rst && lif.write_enable) begin
      mon_got = {lif.write_select, lif.imem_input};
      mem[lif.write_select] = lif.imem_input;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL write_unexpected: got 0x%0h, expected no write", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        check("write_addr_data", 32'(mon_got), 32'(mon_exp));
      end
      if (tight && mon_load_id == load_id)
        check("write_spacing", 32'(cyc - prev_we_cyc), 32'd3);
      prev_we_cyc = cyc;
      mon_load_id = load_id;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_sum();
    int s = 0;
    for (int i = 0; i < NBYTES; i++) s += int'(img[i]);
    return 8'(s % 256);
  endfunction

  task automatic fill_img(input bit counting);
    for (int i = 0; i < NBYTES; i++)
      img[i] = counting ? 8'(i) : 8'($urandom_range(0, 255));
    img[NBYTES] = ref_sum();
  endtask

  // ---------------- drivers ----------------
  task automatic drive_stream(input int n, input int gap_max, input int poke_idx);
    int i = 0;
    int budget = 0;
    bit rdy;
    bit poked = 1'b0;
    while (i < n && budget < 4000) begin
      if (gap_max > 0 && $urandom_range(0, 2) == 0) begin
        lif.byte_valid = 1'b0;
        repeat ($urandom_range(1, gap_max)) @(negedge clk);
        budget += 5;
      end
      lif.byte_valid = 1'b1;
      lif.byte_in    = img[i];
      lif.start      = (i == poke_idx) && !poked;
      if (i == poke_idx) poked = 1'b1;
      rdy = lif.byte_ready;
      @(negedge clk);
      budget++;
      lif.start = 1'b0;
      if (rdy) i++;
    end
    lif.byte_valid = 1'b0;
    check("stream_complete", 32'(i), 32'(n));
  endtask

  task automatic wait_done();
    int t = 0;
    while (!lif.done && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("done_reached", 32'(lif.done), 32'd1);
  endtask

  task automatic run_load(input int gap, input int poke_idx, input int n_words);
    bit full;
    bit exp_err;
    full = (n_words == DEPTH);
    load_id++;
    tight = (gap == 0);
    for (int k = 0; k < n_words; k++)
      exp_q.push_back({ADDR_W'(k), img[2*k], img[2*k+1]});
    @(negedge clk);
    lif.start      = 1'b1;
    lif.byte_valid = 1'b1;
    lif.byte_in    = img[0];
    @(negedge clk);
    lif.start = 1'b0;
    check("hold_after_start", 32'(lif.cpu_hold), 32'd1);
    check("busy_after_start", 32'(lif.busy), 32'd1);
    check("done_cleared", 32'(lif.done), 32'd0);
    check("ready_after_start", 32'(lif.byte_ready), 32'd1);
    drive_stream(2 * n_words + ((full && CSUM_ON) ? 1 : 0), gap, poke_idx);
    if (full) begin
      wait_done();
      exp_err = CSUM_ON && (img[NBYTES] != ref_sum());
      check("hold_at_done", 32'(lif.cpu_hold), 32'd0);
      check("busy_at_done", 32'(lif.busy), 32'd0);
      check("ready_at_done", 32'(lif.byte_ready), 32'd0);
      check("state_done", 32'(dbg_state), 32'(ST_DONE));
      check("error_at_done", 32'(lif.error), 32'(exp_err));
      check("writes_outstanding", 32'(exp_q.size()), 32'd0);
      for (int k = 0; k < DEPTH; k++)
        check("imem_contents", 32'(mem[k]), 32'({img[2*k], img[2*k+1]}));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(lif.byte_ready), 32'd0);
    check({tag, "_we"}, 32'(lif.write_enable), 32'd0);
    check({tag, "_wsel"}, 32'(lif.write_select), 32'd0);
    check({tag, "_data"}, 32'(lif.imem_input), 32'd0);
    check({tag, "_hold"}, 32'(lif.cpu_hold), 32'd0);
    check({tag, "_busy"}, 32'(lif.busy), 32'd0);
    check({tag, "_done"}, 32'(lif.done), 32'd0);
    check({tag, "_error"}, 32'(lif.error), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    lif.start      = 1'b0;
    lif.byte_valid = 1'b0;
    lif.byte_in    = 8'h00;
    for (int k = 0; k < DEPTH; k++) mem[k] = '0;

    #12;
    check_reset_outputs("reset_initial");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Counting image, valid held high throughout.
    fill_img(1'b1);
    run_load(0, -1, DEPTH);

    // Random data with random source gaps.
    for (int r = 0; r < 3; r++) begin
      fill_img(1'b0);
      run_load(5, -1, DEPTH);
    end

    // START poked while loading address 5 must be ignored; then restart from DONE.
    fill_img(1'b0);
    run_load(0, 10, DEPTH);
    fill_img(1'b0);
    run_load(0, -1, DEPTH);

    // Reset after word 7 is written, then a full reload overwrites everything.
    fill_img(1'b0);
    run_load(0, -1, 8);
    @(posedge clk);
    #3;
    check("hold_before_reset", 32'(lif.cpu_hold), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_midload");
    check("partial_writes", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fill_img(1'b0);
    run_load(3, -1, DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
    fill_img(1'b1);
    img[NBYTES] = 8'hF0;
    run_load(0, -1, DEPTH);
    fill_img(1'b1);
    img[NBYTES] = 8'hF1;
    run_load(0, -1, DEPTH);
    fill_img(1'b0);
    img[NBYTES] = 8'($urandom_range(0, 255));
    run_load(2, -1, DEPTH);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
